// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
// Holds the control state encoding, the default geometry and the signed
// saturation limits for the default width. Modules built at other widths
// derive their own limits from WIDTH the same way.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SLICE = 4;
  localparam int unsigned SLICES    = DEF_WIDTH / DEF_SLICE;

  // Largest positive / most negative two's-complement values at DEF_WIDTH.
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/slice_subtractor.sv
// Combinational SLICE-bit subtract step: a + ~b + ~borrow_in.
// Ports:
//   a, b        slice of minuend / subtrahend
//   borrow_in   borrow from the previous (less significant) slice
//   s           slice difference
//   borrow_out  borrow into the next slice (inverse of the adder carry-out)
//   carry_msb   adder carry into the slice MSB, used for signed overflow
module slice_subtractor #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             borrow_in,
  output logic [SLICE-1:0] s,
  output logic             borrow_out,
  output logic             carry_msb
);

  logic [SLICE:0] sum;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~borrow_in};
    s          = sum[SLICE-1:0];
    borrow_out = ~sum[SLICE];
    // Carry into the MSB recovered from the MSB sum bit and its two addends.
    carry_msb  = sum[SLICE-1] ^ a[SLICE-1] ^ ~b[SLICE-1];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b - b_in.
// One SLICE-bit slice is processed per clock, LSB first, with the borrow
// held in a register between cycles. Valid/ready handshake on both sides.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid, in_ready     operand handshake (a, b, b_in captured on accept)
//   out_valid, out_ready   result handshake
//   diff, b_out, overflow  result, unsigned borrow out, signed overflow
// Build option: define SUB_SATURATE_EN to replace diff with the signed
// saturation limit whenever overflow is set.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
);

  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W   = $clog2(NSLICES + 1);

  if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_geometry
    $error("nibble_serial_subtractor: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             ovf_q;

`ifdef SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
  logic sign_q;
`endif

  logic [SLICE-1:0] slice_s;
  logic             slice_borrow;
  logic             slice_cmsb;

  slice_subtractor #(.SLICE(SLICE)) u_slice (
    .a          (a_sh[SLICE-1:0]),
    .b          (b_sh[SLICE-1:0]),
    .borrow_in  (borrow),
    .s          (slice_s),
    .borrow_out (slice_borrow),
    .carry_msb  (slice_cmsb)
  );

  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      borrow    <= 1'b0;
      ovf_q     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
`ifdef SUB_SATURATE_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= b_in;
            cnt    <= '0;
            state  <= RUN;
`ifdef SUB_SATURATE_EN
            sign_q <= a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (cnt != CNT_W'(NSLICES)) begin
            diff[cnt*SLICE +: SLICE] <= slice_s;
            borrow <= slice_borrow;
            // Overflow of the slice just computed; only the last one survives.
            ovf_q  <= slice_cmsb ^ ~slice_borrow;
            a_sh   <= a_sh >> SLICE;
            b_sh   <= b_sh >> SLICE;
            cnt    <= cnt + 1'b1;
          end else begin
            // Extra finalize cycle after the last slice publishes the flags,
            // giving an accept-to-valid latency of SLICES+1 clocks.
            b_out     <= borrow;
            overflow  <= ovf_q;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB_SATURATE_EN
            if (ovf_q) begin
              diff <= sign_q ? SAT_LO : SAT_HI;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        b_out;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;
  } res_t;

  nibble_serial_subtractor #(.WIDTH(W), .SLICE(NS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: widened unsigned for borrow, plain int for overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    res_t        r;
    logic [16:0] u;
    int          sr;
    u  = {1'b0, x} - {1'b0, y} - {16'b0, bi};
    sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
    r.diff  = u[15:0];
    r.b_out = u[16];
    r.ovf   = (sr > 32767) || (sr < -32768);
`ifdef SUB_SATURATE_EN
    if (r.ovf) r.diff = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level model: busy flag plus countdown to result.
  logic m_busy = 1'b0;
  logic m_zero = 1'b0;
  logic armed  = 1'b0;
  int   m_wait = 0;
  res_t m_exp;

  always @(negedge clk) begin
    if (armed) begin
      chk("mon in_ready", 32'(in_ready), 32'(rst_n && !m_busy));
      chk("mon out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
      if (m_busy && m_wait == 0) begin
        chk("mon diff", 32'(diff), 32'(m_exp.diff));
        chk("mon b_out", 32'(b_out), 32'(m_exp.b_out));
        chk("mon overflow", 32'(overflow), 32'(m_exp.ovf));
      end else if (m_zero) begin
        chk("mon diff after reset", 32'(diff), 32'h0);
        chk("mon b_out after reset", 32'(b_out), 32'h0);
        chk("mon overflow after reset", 32'(overflow), 32'h0);
      end
    end
    // Inputs are stable until after the next posedge: decide its effect now.
    if (!rst_n) begin
      m_busy = 1'b0;
      m_wait = 0;
      m_zero = 1'b1;
      armed  = 1'b1;
    end else if (armed) begin
      if (!m_busy && in_valid) begin
        m_busy = 1'b1;
        m_wait = NS + 1;
        m_exp  = model(a, b, b_in);
        m_zero = 1'b0;
      end else if (m_busy && m_wait > 0) begin
        m_wait = m_wait - 1;
      end else if (m_busy && out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input logic [15:0] e_raw, input logic [15:0] e_sat,
                        input logic e_bout, input logic e_ovf, input int hold);
    int          n;
    int          lat;
    logic [15:0] e_diff;
    res_t        m;
`ifdef SUB_SATURATE_EN
    e_diff = e_sat;
`else
    e_diff = e_raw;
`endif
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready before accept", 32'(in_ready), 32'h1);
    a = ta; b = tb_v; b_in = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd5);
    m = model(ta, tb_v, tbin);
    chk("model diff", 32'(m.diff), 32'(e_diff));
    chk("model b_out", 32'(m.b_out), 32'(e_bout));
    chk("model overflow", 32'(m.ovf), 32'(e_ovf));
    chk("diff", 32'(diff), 32'(e_diff));
    chk("b_out", 32'(b_out), 32'(e_bout));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = 16'($urandom);
      @(posedge clk); #1;
      chk("hold out_valid", 32'(out_valid), 32'h1);
      chk("hold in_ready", 32'(in_ready), 32'h0);
      chk("hold diff", 32'(diff), 32'(e_diff));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released out_valid", 32'(out_valid), 32'h0);
    chk("released in_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset diff", 32'(diff), 32'h0);
    chk("reset b_out", 32'(b_out), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);

    //      a         b         bin   raw       sat       bout  ovf   hold
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op(16'h0005, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0003, 16'h0003, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op(16'h0000, 16'h8000, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 0);
    // Backpressure: result held for 10 cycles while in_valid toggles.
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 16'h8000, 1'b0, 1'b1, 10);
    run_op(16'h0042, 16'h0002, 1'b0, 16'h0040, 16'h0040, 1'b0, 1'b0, 0);

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h1234; b = 16'h4321; b_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'h0);
    chk("abort diff", 32'(diff), 32'h0);
    chk("abort b_out", 32'(b_out), 32'h0);
    chk("abort overflow", 32'(overflow), 32'h0);
    chk("abort in_ready", 32'(in_ready), 32'h1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort no result", 32'(out_valid), 32'h0);
    end
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
